pc_call_ctrl: RTL and testbench

- Program-counter and call/return sequencer for the 19-bit CPU.
- Holds the fetch PC and advances it each cycle.
- Applies jumps and calls, and drives the return-address stack.
- On a call it pushes the return address to the stack. On a return it pops the stack and consumes the popped address one cycle later.

---
 rtl/pc_call_ctrl_pkg.sv | 15 +
 rtl/pc_call_ctrl_if.sv | 32 +++
 rtl/pc_call_ctrl.sv | 101 ++++++++++
 tb/tb_pc_call_ctrl.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/pc_call_ctrl_pkg.sv
// Shared CPU constants for the program-counter / call-return sequencer.
// Holds address width, fetch step, return-stack depth and the sequencer state encoding.
package cpu_pkg;

    localparam int PC_W        = 19;
    localparam int PC_STEP     = 1;
    localparam int STACK_DEPTH = 256;
    localparam int DEPTH_W     = $clog2(STACK_DEPTH + 1);

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_RET_WAIT = 1'b1
    } seq_state_e;

endpackage

// File: rtl/pc_call_ctrl_if.sv
// Request/response bundle between the fetch front-end, the return-address stack
// and the PC sequencer; the sequencer takes the slave side.
interface pc_call_ctrl_if;
    import cpu_pkg::*;

    logic               stall;
    logic               jump;
    logic [PC_W-1:0]    jump_target;
    logic               call;
    logic [PC_W-1:0]    call_target;
    logic               ret;
    logic [PC_W-1:0]    ret_addr;
    logic               push;
    logic               pop;
    logic [PC_W-1:0]    push_data;
    logic [PC_W-1:0]    pc;
    logic               busy;
    logic [DEPTH_W-1:0] depth;
    logic               ovf;
    logic               unf;

    modport master (
        output stall, jump, jump_target, call, call_target, ret, ret_addr,
        input  push, pop, push_data, pc, busy, depth, ovf, unf
    );

    modport slave (
        input  stall, jump, jump_target, call, call_target, ret, ret_addr,
        output push, pop, push_data, pc, busy, depth, ovf, unf
    );

endinterface

// File: rtl/pc_call_ctrl.sv
// Fetch PC sequencer: advances the PC, applies jumps and calls, and drives
// push/pop strobes to the external return-address stack.
module pc_call_ctrl
    import cpu_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst,
    pc_call_ctrl_if.slave bus
);

    localparam logic [PC_W-1:0]    STEP_V = PC_W'(PC_STEP);
    localparam logic [DEPTH_W-1:0] FULL_V = DEPTH_W'(STACK_DEPTH);

    seq_state_e         state_q;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [PC_W-1:0]    pushData_q;
    logic               push_q, pop_q;
    logic [DEPTH_W-1:0] depth_q;
    logic               ovf_q, unf_q;
    logic [PC_W-1:0]    pcInc;
    logic               stackEmpty, stackFull;

    assign pcInc      = pc_q + STEP_V;
    assign stackEmpty = (depth_q == '0);
    assign stackFull  = (depth_q == FULL_V);

    // Next-PC select; dropped calls and underflowing returns fall through to a plain increment.
    always_comb begin
        pc_d = pcInc;
        if (state_q == ST_RET_WAIT) begin
            pc_d = bus.ret_addr;
        end else if (bus.stall) begin
            pc_d = pc_q;
        end else if (bus.ret) begin
            pc_d = stackEmpty ? pcInc : pc_q;
        end else if (bus.call) begin
            pc_d = stackFull ? pcInc : bus.call_target;
        end else if (bus.jump) begin
            pc_d = bus.jump_target;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RUN;
            pc_q       <= RESET_PC;
            push_q     <= 1'b0;
            pop_q      <= 1'b0;
            pushData_q <= '0;
            depth_q    <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            push_q <= 1'b0;
            pop_q  <= 1'b0;
            case (state_q)
                ST_RUN: begin
                    if (!bus.stall) begin
                        if (bus.ret) begin
                            if (!stackEmpty) begin
                                pop_q   <= 1'b1;
                                depth_q <= depth_q - 1'b1;
                                state_q <= ST_RET_WAIT;
                            end else begin
                                unf_q <= 1'b1;
                            end
                        end else if (bus.call) begin
                            if (!stackFull) begin
                                push_q     <= 1'b1;
                                pushData_q <= pcInc;
                                depth_q    <= depth_q + 1'b1;
                            end else begin
                                ovf_q <= 1'b1;
                            end
                        end
                    end
                end
                // The popped address arrives this cycle; every request is ignored until it lands.
                ST_RET_WAIT: begin
                    state_q <= ST_RUN;
                end
                default: begin
                    state_q <= ST_RUN;
                end
            endcase
        end
    end

    assign bus.pc        = pc_q;
    assign bus.push      = push_q;
    assign bus.pop       = pop_q;
    assign bus.push_data = pushData_q;
    assign bus.busy      = (state_q == ST_RET_WAIT);
    assign bus.depth     = depth_q;
    assign bus.ovf       = ovf_q;
    assign bus.unf       = unf_q;

endmodule

// File: tb/tb_pc_call_ctrl.sv
// Directed bench for pc_call_ctrl: sequential fetch, call/return, under/overflow,
// wrap-around, request priority and reset during a pending return.
module tb_pc_call_ctrl;
    import cpu_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   vectors     = 0;
    int   miscompares = 0;
    int   pushes;

    always #5 clk = ~clk;

    pc_call_ctrl_if bus ();

    pc_call_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic applyStimulus(input logic s, input logic r, input logic c, input logic j,
                                 input logic [PC_W-1:0] jt, input logic [PC_W-1:0] ct,
                                 input logic [PC_W-1:0] ra);
        bus.stall       = s;
        bus.ret         = r;
        bus.call        = c;
        bus.jump        = j;
        bus.jump_target = jt;
        bus.call_target = ct;
        bus.ret_addr    = ra;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, '0, '0, '0);
        tick;
        tick;
        checkOutput("reset pc", 32'(bus.pc), 32'h0);
        checkOutput("reset push", 32'(bus.push), 32'h0);
        checkOutput("reset pop", 32'(bus.pop), 32'h0);
        checkOutput("reset depth", 32'(bus.depth), 32'h0);
        checkOutput("reset push_data", 32'(bus.push_data), 32'h0);
        rst = 1'b0;

        for (int i = 1; i <= 4; i++) begin
            tick;
            checkOutput("sequential pc", 32'(bus.pc), 32'(i));
        end
        checkOutput("idle push/pop", 32'({bus.push, bus.pop}), 32'h0);

        applyStimulus(0, 0, 0, 1, 19'h00010, '0, '0);
        tick;
        checkOutput("jump pc", 32'(bus.pc), 32'h10);

        applyStimulus(0, 0, 1, 0, '0, 19'h00400, '0);
        tick;
        checkOutput("call push", 32'(bus.push), 32'h1);
        checkOutput("call push_data", 32'(bus.push_data), 32'h11);
        checkOutput("call pc", 32'(bus.pc), 32'h400);
        checkOutput("call depth", 32'(bus.depth), 32'h1);

        applyStimulus(0, 1, 0, 0, '0, '0, 19'h00011);
        tick;
        checkOutput("ret pop", 32'(bus.pop), 32'h1);
        checkOutput("ret busy", 32'(bus.busy), 32'h1);
        checkOutput("ret pc held", 32'(bus.pc), 32'h400);
        checkOutput("ret push low", 32'(bus.push), 32'h0);

        // A call during the wait cycle must be ignored.
        applyStimulus(0, 0, 1, 0, '0, 19'h00555, 19'h00011);
        tick;
        checkOutput("ret_wait pc", 32'(bus.pc), 32'h11);
        checkOutput("ret_wait pop", 32'(bus.pop), 32'h0);
        checkOutput("ret_wait busy", 32'(bus.busy), 32'h0);
        checkOutput("ret_wait depth", 32'(bus.depth), 32'h0);
        checkOutput("ret_wait push", 32'(bus.push), 32'h0);

        applyStimulus(0, 0, 0, 1, 19'h00020, '0, '0);
        tick;
        checkOutput("jump 0x20", 32'(bus.pc), 32'h20);

        applyStimulus(0, 1, 0, 0, '0, '0, 19'h01234);
        tick;
        checkOutput("underflow pop", 32'(bus.pop), 32'h0);
        checkOutput("underflow unf", 32'(bus.unf), 32'h1);
        checkOutput("underflow pc", 32'(bus.pc), 32'h21);
        checkOutput("underflow busy", 32'(bus.busy), 32'h0);

        applyStimulus(0, 0, 0, 0, '0, '0, '0);
        tick;
        checkOutput("unf sticky", 32'(bus.unf), 32'h1);
        checkOutput("pc after unf", 32'(bus.pc), 32'h22);

        applyStimulus(1, 0, 1, 1, 19'h00999, 19'h00300, '0);
        tick;
        checkOutput("stall pc", 32'(bus.pc), 32'h22);
        checkOutput("stall push", 32'(bus.push), 32'h0);
        checkOutput("stall depth", 32'(bus.depth), 32'h0);

        applyStimulus(0, 0, 1, 1, 19'h00999, 19'h00300, '0);
        tick;
        checkOutput("call over jump pc", 32'(bus.pc), 32'h300);
        checkOutput("call over jump push_data", 32'(bus.push_data), 32'h23);
        checkOutput("call over jump depth", 32'(bus.depth), 32'h1);

        applyStimulus(0, 0, 1, 0, '0, 19'h00300, '0);
        pushes = 0;
        for (int i = 0; i < 255; i++) begin
            tick;
            pushes += int'(bus.push);
        end
        checkOutput("back-to-back pushes", 32'(pushes), 32'd255);
        checkOutput("full depth", 32'(bus.depth), 32'd256);
        checkOutput("full push_data", 32'(bus.push_data), 32'h301);

        tick;
        checkOutput("overflow push", 32'(bus.push), 32'h0);
        checkOutput("overflow ovf", 32'(bus.ovf), 32'h1);
        checkOutput("overflow depth", 32'(bus.depth), 32'd256);
        checkOutput("overflow pc", 32'(bus.pc), 32'h301);

        applyStimulus(0, 0, 0, 1, 19'h7FFFF, '0, '0);
        tick;
        checkOutput("jump 0x7FFFF", 32'(bus.pc), 32'h7FFFF);
        checkOutput("ovf sticky", 32'(bus.ovf), 32'h1);

        applyStimulus(0, 0, 0, 0, '0, '0, '0);
        tick;
        checkOutput("pc wrap", 32'(bus.pc), 32'h0);

        applyStimulus(0, 1, 0, 0, '0, '0, 19'h01234);
        tick;
        checkOutput("pre-reset pop", 32'(bus.pop), 32'h1);
        checkOutput("pre-reset busy", 32'(bus.busy), 32'h1);
        checkOutput("pre-reset depth", 32'(bus.depth), 32'd255);

        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, '0, '0, 19'h01234);
        tick;
        checkOutput("rst in wait pc", 32'(bus.pc), 32'h0);
        checkOutput("rst in wait pop", 32'(bus.pop), 32'h0);
        checkOutput("rst in wait busy", 32'(bus.busy), 32'h0);
        checkOutput("rst in wait depth", 32'(bus.depth), 32'h0);
        checkOutput("rst in wait flags", 32'({bus.ovf, bus.unf}), 32'h0);

        rst = 1'b0;
        tick;
        checkOutput("run after rst", 32'(bus.pc), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
